// File: rtl/filter_output_pkg.sv
`default_nettype none
// ============================================================================
// filter_output_pkg: shared helpers for filter output conditioning stages.
// Rev 1.0
// ============================================================================
package filter_output_pkg;

  // Wide enough for any input up to 64 bits plus the rounding carry.
  localparam int unsigned c_CALC_W = 65;

  typedef logic signed [c_CALC_W-1:0] calc_t;

  typedef struct packed {
    calc_t value;
    logic  sat;
  } rss_t;

  function automatic int unsigned fifo_addr_w(input int unsigned depth);
    return (depth > 1) ? int'($clog2(depth)) : 1;
  endfunction

  function automatic calc_t sat_max(input int unsigned out_w);
    return (calc_t'(1) <<< (out_w - 1)) - calc_t'(1);
  endfunction

  function automatic calc_t sat_min(input int unsigned out_w);
    return -(calc_t'(1) <<< (out_w - 1));
  endfunction

  // Round-half-up, arithmetic shift right, then clamp to out_w signed bits.
  function automatic rss_t round_shift_sat(input calc_t din,
                                           input int unsigned shift,
                                           input int unsigned out_w);
    calc_t sum;
    calc_t scaled;
    rss_t  res;
    sum    = din + ((shift > 0) ? (calc_t'(1) <<< (shift - 1)) : calc_t'(0));
    scaled = sum >>> shift;
    res.sat = 1'b1;
    if (scaled > sat_max(out_w)) begin
      res.value = sat_max(out_w);
    end else if (scaled < sat_min(out_w)) begin
      res.value = sat_min(out_w);
    end else begin
      res.value = scaled;
      res.sat   = 1'b0;
    end
    return res;
  endfunction

endpackage
`default_nettype wire

// File: rtl/sync_fifo.sv
`default_nettype none
// ============================================================================
// sync_fifo: single-clock FIFO with occupancy output and registered pointers.
// Rev 1.0
// ============================================================================
module sync_fifo
  import filter_output_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_wr_en,
  input  logic [WIDTH-1:0]         i_wr_data,
  input  logic                     i_rd_en,
  output logic [WIDTH-1:0]         o_rd_data,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_level
);

  localparam int c_AW = int'(fifo_addr_w(DEPTH));
  localparam logic [c_AW:0] c_FULL = DEPTH[c_AW:0];

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [c_AW-1:0]  r_wr_ptr;
  logic [c_AW-1:0]  r_rd_ptr;
  logic [c_AW:0]    r_level;
  logic             w_wr;
  logic             w_rd;

  assign o_empty = (r_level == '0);
  assign w_rd    = i_rd_en && !o_empty;
  assign w_wr    = i_wr_en && (r_level != c_FULL);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_wr) r_wr_ptr <= r_wr_ptr + c_AW'(1);
      if (w_rd) r_rd_ptr <= r_rd_ptr + c_AW'(1);
      case ({w_wr, w_rd})
        2'b10:   r_level <= r_level + (c_AW+1)'(1);
        2'b01:   r_level <= r_level - (c_AW+1)'(1);
        default: r_level <= r_level;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_wr) r_mem[r_wr_ptr] <= i_wr_data;
  end

  // Head is masked while empty so stale entries never appear on the bus.
  assign o_rd_data = o_empty ? '0 : r_mem[r_rd_ptr];
  assign o_level   = r_level;

endmodule
`default_nettype wire

// File: rtl/filter_output_conditioner.sv
`default_nettype none
// ============================================================================
// filter_output_conditioner: round/scale/saturate stage plus output FIFO.
// FILTER_OUTPUT_CONDITIONER_SAT_COUNT_EN builds the saturation counter. Rev 1.0
// ============================================================================
module filter_output_conditioner
  import filter_output_pkg::*;
#(
  parameter int DATA_IN_WIDTH   = 16,
  parameter int DATA_OUT_WIDTH  = 12,
  parameter int SHIFT           = 4,
  parameter int FIFO_DEPTH      = 8,
  parameter int SAT_COUNT_WIDTH = 16
) (
  input  logic                              clock,
  input  logic                              reset,
  input  logic                              data_in_tvalid,
  output logic                              data_in_tready,
  input  logic signed [DATA_IN_WIDTH-1:0]   data_in_tdata,
  input  logic                              data_in_tlast,
  output logic                              data_out_tvalid,
  input  logic                              data_out_tready,
  output logic signed [DATA_OUT_WIDTH-1:0]  data_out_tdata,
  output logic                              data_out_tlast,
  output logic [$clog2(FIFO_DEPTH):0]       fifo_level,
  input  logic                              sat_count_clear,
  output logic [SAT_COUNT_WIDTH-1:0]        sat_count
);

  localparam int c_LVL_W   = $clog2(FIFO_DEPTH) + 1;
  localparam int c_CMP_W   = c_LVL_W + 1;
  localparam int c_ENTRY_W = DATA_OUT_WIDTH + 1;

  rss_t                             w_rss;
  logic                             w_in_hs;
  logic                             r_s1_valid;
  logic signed [DATA_OUT_WIDTH-1:0] r_s1_data;
  logic                             r_s1_last;
  logic [c_ENTRY_W-1:0]             w_fifo_rd_data;
  logic                             w_fifo_empty;
  logic                             w_unused_hi;

  assign w_rss   = round_shift_sat(calc_t'(data_in_tdata), SHIFT, DATA_OUT_WIDTH);
  assign w_in_hs = data_in_tvalid && data_in_tready;

  // Stage 1 is counted as occupied so a full FIFO can always absorb it.
  assign data_in_tready = !reset &&
    (({1'b0, fifo_level} + c_CMP_W'(r_s1_valid)) < c_CMP_W'(FIFO_DEPTH));

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_s1_valid <= 1'b0;
      r_s1_data  <= '0;
      r_s1_last  <= 1'b0;
    end else begin
      r_s1_valid <= w_in_hs;
      if (w_in_hs) begin
        r_s1_data <= w_rss.value[DATA_OUT_WIDTH-1:0];
        r_s1_last <= data_in_tlast;
      end
    end
  end

  sync_fifo #(
    .WIDTH (c_ENTRY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clock),
    .rst       (reset),
    .i_wr_en   (r_s1_valid),
    .i_wr_data ({r_s1_last, r_s1_data}),
    .i_rd_en   (data_out_tready),
    .o_rd_data (w_fifo_rd_data),
    .o_empty   (w_fifo_empty),
    .o_level   (fifo_level)
  );

  assign data_out_tvalid = !w_fifo_empty;
  assign data_out_tdata  = w_fifo_rd_data[DATA_OUT_WIDTH-1:0];
  assign data_out_tlast  = w_fifo_rd_data[DATA_OUT_WIDTH];

`ifdef FILTER_OUTPUT_CONDITIONER_SAT_COUNT_EN
  logic                       r_s1_sat;
  logic                       w_sat_wr;
  logic [SAT_COUNT_WIDTH-1:0] r_sat_count;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_s1_sat <= 1'b0;
    end else if (w_in_hs) begin
      r_s1_sat <= w_rss.sat;
    end
  end

  assign w_sat_wr = r_s1_valid && r_s1_sat;

  // Clear wins, but a saturated write on the same edge still counts once.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_sat_count <= '0;
    end else if (sat_count_clear) begin
      r_sat_count <= SAT_COUNT_WIDTH'(w_sat_wr);
    end else if (w_sat_wr && !(&r_sat_count)) begin
      r_sat_count <= r_sat_count + SAT_COUNT_WIDTH'(1);
    end
  end

  assign sat_count   = r_sat_count;
  assign w_unused_hi = ^w_rss.value[c_CALC_W-1:DATA_OUT_WIDTH];
`else
  assign sat_count   = '0;
  assign w_unused_hi = ^{w_rss.value[c_CALC_W-1:DATA_OUT_WIDTH], w_rss.sat, sat_count_clear};
`endif

endmodule
`default_nettype wire
